// File: rtl/pattern_serializer_pkg.sv
// pat_pkg: shared geometry constants and FSM state type for the pattern serializer
// Exports BUFFER_SIZE/BUFFER_WIDTH/NUM_BUFFERS defaults and pat_ser_state_t.
package pat_pkg;
  localparam int BUFFER_SIZE = 12;
  localparam int BUFFER_WIDTH = 8;
  localparam int NUM_BUFFERS = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ADVANCE} pat_ser_state_t;
endpackage

// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if: control, buffer and serial-stream bundle between bank/sink and serializer
// master drives start/stop/loop_en/last_field/buffer_flat/pat_ready and observes the rest;
// slave (the serializer) drives bufp/fieldp/pat_out/pat_valid/busy/done.
interface pattern_serializer_if import pat_pkg::*; #(
  parameter int BS = BUFFER_SIZE,
  parameter int BW = BUFFER_WIDTH,
  parameter int NB = NUM_BUFFERS
) ();
  logic start, stop, loop_en, pat_ready;
  logic [3:0] last_field;
  logic [BS*BW-1:0] buffer_flat;
  logic [$clog2(NB)-1:0] bufp;
  logic [BS-1:0] fieldp;
  logic pat_out, pat_valid, busy, done;
  modport master (
    output start, stop, loop_en, last_field, buffer_flat, pat_ready,
    input bufp, fieldp, pat_out, pat_valid, busy, done
  );
  modport slave (
    input start, stop, loop_en, last_field, buffer_flat, pat_ready,
    output bufp, fieldp, pat_out, pat_valid, busy, done
  );
endinterface

// File: rtl/pattern_serializer_shift.sv
// pat_shift_reg: parallel-load, ready-gated MSB-first shifter with bit counter and last-bit flag
// Ports: clk, reset (async high), i_load (capture i_data), i_shift (bit accepted),
// o_msb (current serial bit), o_last (current bit is the final one of the byte).
module pat_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb,
  output logic         o_last
);
  localparam int CW = $clog2(W);
  logic [W-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
      r_cnt <= CW'(W - 1);
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
      r_cnt <= r_cnt - 1'b1;
    end
  assign o_msb = r_sr[W-1];
  assign o_last = r_cnt == '0;
endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: walks the fields of the selected buffer and streams each byte MSB-first
// Ports: clk, reset (async high), bus (pattern_serializer_if.slave) carrying start/stop/loop_en,
// last_field, buffer_flat, pat_ready in and bufp, fieldp, pat_out, pat_valid, busy, done out.
module pattern_serializer import pat_pkg::*; #(
  parameter int BS = BUFFER_SIZE,
  parameter int BW = BUFFER_WIDTH,
  parameter int NB = NUM_BUFFERS
) (
  input logic clk,
  input logic reset,
  pattern_serializer_if.slave bus
);
  localparam int PW = $clog2(NB);
  pat_ser_state_t r_state;
  logic [3:0] r_idx;
  logic [BS-1:0] r_fieldp;
  logic [PW-1:0] r_bufp;
  logic r_done;
  logic w_msb, w_last, w_fire, w_at_end, w_load;
  logic [3:0] w_last_idx;
  logic [BW-1:0] w_byte;
  assign w_last_idx = int'(bus.last_field) >= BS ? 4'(BS - 1) : bus.last_field;
  assign w_fire = r_state == SHIFT && bus.pat_ready;
  assign w_at_end = r_idx == w_last_idx;
  assign w_load = r_state == LOAD;
  assign w_byte = bus.buffer_flat[r_idx*BW +: BW];
  pat_shift_reg #(.W(BW)) u_sr (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .i_shift(w_fire),
    .i_data(w_byte),
    .o_msb(w_msb),
    .o_last(w_last)
  );
  // bufp advances on the edge entering ADVANCE, while fieldp is frozen; fieldp only
  // rewinds on the following edge, so the two pointers never move together.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_fieldp <= BS'(1);
      r_bufp <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state <= IDLE;
        r_idx <= '0;
        r_fieldp <= BS'(1);
      end else
        case (r_state)
          IDLE:
            if (bus.start) begin
              r_state <= LOAD;
              r_idx <= '0;
              r_fieldp <= BS'(1);
            end
          LOAD: r_state <= SHIFT;
          SHIFT:
            if (w_fire && w_last) begin
              if (w_at_end) begin
                r_state <= ADVANCE;
                r_bufp <= r_bufp == PW'(NB - 1) ? '0 : r_bufp + 1'b1;
              end else begin
                r_state <= LOAD;
                r_idx <= r_idx + 1'b1;
                r_fieldp <= r_fieldp << 1;
              end
            end
          ADVANCE: begin
            r_state <= bus.loop_en ? LOAD : IDLE;
            r_idx <= '0;
            r_fieldp <= BS'(1);
            r_done <= !bus.loop_en;
          end
          default: r_state <= IDLE;
        endcase
    end
  assign bus.bufp = r_bufp;
  assign bus.fieldp = r_fieldp;
  assign bus.pat_valid = r_state == SHIFT;
  assign bus.pat_out = bus.pat_valid & w_msb;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  a_ptr_exclusive: assert property (@(posedge clk) disable iff (reset)
    r_bufp == $past(r_bufp) || r_fieldp == $past(r_fieldp));
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Downstream consumer of the pattern buffer bank. It walks the fields of the currently selected buffer and shifts each byte out MSB-first on a bit-serial pattern output with valid/ready backpressure. It drives the buffer pointer (bufp) and the one-hot field pointer (fieldp) back to the bank, and it never advances both pointers in the same cycle.

Parameters:
buffer_size, 12, fields (bytes) per buffer
buffer_width, 8, bits per field
num_buffers, 8, buffers in the bank; bufp wraps modulo this value

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins playback of buffer bufp; ignored unless idle
stop  input  1  abort playback; takes effect on the next edge
loop_en  input  1  after the last field, advance bufp and continue instead of stopping
last_field  input  4  index of the final field to play; values >= buffer_size clamp to buffer_size-1
buffer_flat  input  buffer_size*buffer_width  current buffer contents; field i is bits [i*buffer_width +: buffer_width]
pat_ready  input  1  sink accepts the current bit
bufp  output  3  buffer pointer to the bank
fieldp  output  buffer_size  one-hot field read pointer
pat_out  output  1  serial pattern bit
pat_valid  output  1  pat_out is valid
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when playback ends normally

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; bufp=0; fieldp=1 (field 0); pat_out=0; pat_valid=0; busy=0; done=0; shift register and counters cleared.
- All state changes occur on the rising edge of clk. The FSM has four states: IDLE, LOAD, SHIFT and ADVANCE.
- IDLE:
  - start=1 -> LOAD with field index 0; fieldp=1.
  - start is ignored in every other state.
- LOAD (one cycle):
  - Capture field[index] from buffer_flat into the shift register.
  - Bit counter = buffer_width-1.
  - Next state is SHIFT.
- SHIFT:
  - pat_valid=1 and pat_out = shift register MSB.
  - On pat_valid && pat_ready: shift left and decrement the bit counter.
  - pat_ready=0 holds pat_out and the counter unchanged.
  - When the bit at counter 0 is accepted:
    - index == clamped last_field -> ADVANCE.
    - Otherwise index+1 and fieldp shifts left by 1 in the same edge -> LOAD.
- ADVANCE (one cycle, pat_valid=0):
  - bufp = (bufp+1) mod num_buffers.
  - fieldp is not changed in this cycle.
  - loop_en=1 -> LOAD, with index=0 and fieldp=1 on that edge.
  - loop_en=0 -> IDLE, done=1 for one cycle, fieldp returns to 1.
- Latency without stalls:
  - start sampled at edge 0; LOAD during cycle 1; first bit valid in cycle 2.
  - Each byte costs 1 + buffer_width cycles.
- stop: from any non-IDLE state go to IDLE on the next edge.
  - pat_valid drops and bufp is kept unchanged.
  - fieldp returns to 1 and done is not pulsed.
  - stop has priority over all other transitions.
- Simultaneous start and stop while IDLE: stop wins and the block stays IDLE.
- buffer_flat is sampled only in LOAD. Changes during SHIFT do not affect the byte in flight.
- bufp wraps from num_buffers-1 to 0.
- Pointer rule: bufp and fieldp never change on the same edge. An assertion must check this.
- A reset asserted mid-byte aborts immediately; no partial state survives.

Decomposition:
- Shared package pat_pkg holds:
  - FSM state enum pat_ser_state_t {IDLE, LOAD, SHIFT, ADVANCE};
  - the default constants BUFFER_SIZE=12, BUFFER_WIDTH=8 and NUM_BUFFERS=8.
- One natural sub-module: pat_shift_reg, a parallel-load, ready-gated MSB-first shifter with a bit counter and last-bit flag.

Test Plan:
- Single-field playback: reset, bufp=0, last_field=0, field0=8'hA5, pat_ready=1, pulse start.
  - Bits 1,0,1,0,0,1,0,1 appear in cycles 2..9.
  - ADVANCE in cycle 10; done=1 in cycle 11.
  - bufp=1 afterwards and busy=0.
- Multi-field with backpressure: last_field=2, fields 8'h01, 8'h80, 8'hFF; pat_ready deasserted for 3 cycles mid-byte.
  - Output is 24 bits in order with pat_out held during the stall.
  - fieldp steps 1 -> 2 -> 4.
- Loop and wrap: loop_en=1, last_field=0, start with bufp=7.
  - After the first byte, bufp=0 and playback continues into LOAD.
  - fieldp is unchanged in the bufp-change cycle.
- Stop mid-byte: assert stop after 3 bits.
  - Next cycle: IDLE, pat_valid=0, bufp unchanged, fieldp=1, done stays 0.
- Clamp: last_field=15 with buffer_size=12.
  - Exactly 12 bytes are played, then done.
- Async reset mid-SHIFT: assert reset between clock edges.
  - Outputs go to their reset values immediately, without waiting for an edge.
  - A subsequent start plays from field 0 of buffer 0.
